// File: rtl/ln_2to1_pkg.sv
// Shared constants for the 4-phase req/ack link blocks (ln_2to1, ln_1to2).
// Holds the default widths, ON/OFF levels and the common handshake state encoding.
package ln_2to1_pkg;

  localparam int ADDRESS_SIZE = 8;
  localparam int DATA_SIZE    = 8;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Encodings are fixed so the fork block ln_1to2 can decode the same values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_SRC  = 2'd2
  } ln_state_e;

endpackage

// File: rtl/ln_2to1_if.sv
// One 4-phase req/ack link carrying an {addr, dat} message.
// The master modport is the source end, the slave modport is the sink end.
interface ln_2to1_if import ln_2to1_pkg::*; #(
  parameter int ASZ = ADDRESS_SIZE,
  parameter int DSZ = DATA_SIZE
);

  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (output addr, output dat, output req, input ack);
  modport slave  (input addr, input dat, input req, output ack);

endinterface

// File: rtl/ln_2to1_arb2.sv
// ln_arb2: combinational 2-way grant for the link merger.
// LN_2TO1_RR_EN selects round-robin on ties (uses i_last); otherwise input 0 has fixed priority.
module ln_arb2 (
  input  logic i_req0,
  input  logic i_req1,
`ifdef LN_2TO1_RR_EN
  input  logic i_last,
`endif
  output logic o_sel,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req0 | i_req1;
`ifdef LN_2TO1_RR_EN
    // On a tie the port that was not served last wins.
    o_sel = (i_req0 && i_req1) ? ~i_last : i_req1;
`else
    o_sel = ~i_req0 & i_req1;
`endif
  end

endmodule

// File: rtl/ln_2to1.sv
// ln_2to1: merges two 4-phase req/ack links into one, forwarding one whole message at a time.
// Tie policy is set by LN_2TO1_RR_EN (round-robin when defined, input 0 priority otherwise).
//
// state   | meaning
// ST_IDLE | no transfer; grant a requesting input once downstream ack is low
// ST_OUT  | message presented downstream with o_req high, waiting for i_ack
// ST_SRC  | granted source acknowledged, waiting for its req to drop
module ln_2to1 import ln_2to1_pkg::*; #(
  parameter int ASZ = ADDRESS_SIZE,
  parameter int DSZ = DATA_SIZE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ln_2to1_if.slave   s_0,
  ln_2to1_if.slave   s_1,
  ln_2to1_if.master  m_o
);

  ln_state_e      state_q, state_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic           req_q, req_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           sel_q, sel_d;
`ifdef LN_2TO1_RR_EN
  logic           last_q, last_d;
`endif

  logic arb_sel;
  logic arb_valid;
  logic sel_req;

  ln_arb2 u_arb (
    .i_req0  (s_0.req),
    .i_req1  (s_1.req),
`ifdef LN_2TO1_RR_EN
    .i_last  (last_q),
`endif
    .o_sel   (arb_sel),
    .o_valid (arb_valid)
  );

  assign sel_req = sel_q ? s_1.req : s_0.req;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    req_d   = req_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    sel_d   = sel_q;
`ifdef LN_2TO1_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A stale downstream ack keeps us idle until the sink returns to zero.
        if (arb_valid && (m_o.ack == OFF)) begin
          addr_d  = arb_sel ? s_1.addr : s_0.addr;
          dat_d   = arb_sel ? s_1.dat  : s_0.dat;
          req_d   = ON;
          sel_d   = arb_sel;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_o.ack == ON) begin
          req_d = OFF;
          if (sel_q) ack1_d = ON;
          else       ack0_d = ON;
`ifdef LN_2TO1_RR_EN
          last_d = sel_q;
`endif
          state_d = ST_SRC;
        end
      end
      ST_SRC: begin
        if (sel_req == OFF) begin
          ack0_d  = OFF;
          ack1_d  = OFF;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = OFF;
        ack0_d  = OFF;
        ack1_d  = OFF;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
      req_q   <= OFF;
      ack0_q  <= OFF;
      ack1_q  <= OFF;
      sel_q   <= 1'b0;
`ifdef LN_2TO1_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      sel_q   <= sel_d;
`ifdef LN_2TO1_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign m_o.addr = addr_q;
  assign m_o.dat  = dat_q;
  assign m_o.req  = req_q;
  assign s_0.ack  = ack0_q;
  assign s_1.ack  = ack1_q;

  a_ack_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(ack0_q && ack1_q));
  a_req_vs_ack: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(req_q && (ack0_q || ack1_q)));
  a_msg_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (req_q && $past(req_q)) |-> $stable({addr_q, dat_q}));

endmodule
